// File: rtl/max7219_spi_rx_model_if.sv
// SPI pin bundle for the MAX7219 receive model.
// The master drives CS/CLK/Din and the slave model samples them.
interface max7219_spi_rx_model_if;
   logic CS;
   logic CLK;
   logic Din;

   modport master (
      output CS,
      output CLK,
      output Din
   );

   modport slave (
      input CS,
      input CLK,
      input Din
   );
endinterface

// File: rtl/max7219_spi_rx_model.sv
// Synthesizable MAX7219 slave: oversampled SPI into a register image.
// Define MAX7219_RX_TEST_OVERRIDE_EN to force rows high while test_mode=1.
module max7219_spi_rx_model #(
   parameter int SYNC_STAGES = 2
) (
   input  logic                         sys_clk,
   input  logic                         _rst,
   max7219_spi_rx_model_if.slave        spi,
   output logic [63:0]                  rows,
   output logic [7:0]                   decode_mode,
   output logic [3:0]                   intensity,
   output logic [2:0]                   scan_limit,
   output logic                         shutdown_n,
   output logic                         test_mode,
   output logic                         frame_valid,
   output logic [3:0]                   frame_addr,
   output logic [7:0]                   frame_data,
   output logic                         frame_err,
   output logic [15:0]                  frame_cnt
);

   localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [NS-1:0] cs_ff;
   logic [NS-1:0] clk_ff;
   logic [NS-1:0] din_ff;
   logic          cs_s, clk_s, din_s;
   logic          cs_d, clk_d;
   logic          cs_fall, cs_rise, clk_rise;

   logic [15:0]   shreg_q, shreg_d;
   logic [4:0]    bcnt_q, bcnt_d;
   logic [63:0]   rows_q;

   logic          start, shift;
   logic          commit_ok, commit_err;

   logic [3:0]    addr;
   logic [7:0]    data;
   logic [3:0]    addr_m1;
   logic          unused_bits;

   always_ff @(posedge sys_clk or negedge _rst) begin
      if (!_rst) begin
         cs_ff  <= '0;
         clk_ff <= '0;
         din_ff <= '0;
         cs_d   <= 1'b0;
         clk_d  <= 1'b0;
      end else begin
         cs_ff  <= {cs_ff[NS-2:0], spi.CS};
         clk_ff <= {clk_ff[NS-2:0], spi.CLK};
         din_ff <= {din_ff[NS-2:0], spi.Din};
         cs_d   <= cs_s;
         clk_d  <= clk_s;
      end
   end

   assign cs_s     = cs_ff[NS-1];
   assign clk_s    = clk_ff[NS-1];
   assign din_s    = din_ff[NS-1];
   assign cs_fall  = cs_d & ~cs_s;
   assign cs_rise  = ~cs_d & cs_s;
   assign clk_rise = ~clk_d & clk_s;

   always_ff @(posedge sys_clk or negedge _rst) begin
      if (!_rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      start      = 1'b0;
      shift      = 1'b0;
      commit_ok  = 1'b0;
      commit_err = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cs_fall) begin
               state_d = SHIFT;
               start   = 1'b1;
               shift   = clk_rise;
            end
         end
         SHIFT: begin
            // a CLK rise coinciding with the CS rise is dropped
            if (cs_rise) begin
               state_d = COMMIT;
            end else if (clk_rise && !cs_s) begin
               shift = 1'b1;
            end
         end
         COMMIT: begin
            state_d    = IDLE;
            commit_ok  = (bcnt_q == 5'd16);
            commit_err = (bcnt_q != 5'd16);
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      shreg_d = start ? 16'h0000 : shreg_q;
      bcnt_d  = start ? 5'd0 : bcnt_q;
      if (shift) begin
         shreg_d = {shreg_d[14:0], din_s};
         if (bcnt_d != 5'd16) begin
            bcnt_d = bcnt_d + 5'd1;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge _rst) begin
      if (!_rst) begin
         shreg_q <= '0;
         bcnt_q  <= '0;
      end else begin
         shreg_q <= shreg_d;
         bcnt_q  <= bcnt_d;
      end
   end

   assign addr        = shreg_q[11:8];
   assign data        = shreg_q[7:0];
   assign addr_m1     = addr - 4'd1;
   assign unused_bits = ^{shreg_q[15:12], addr_m1[3]};

   always_ff @(posedge sys_clk or negedge _rst) begin
      if (!_rst) begin
         rows_q      <= '0;
         decode_mode <= '0;
         intensity   <= '0;
         scan_limit  <= '0;
         shutdown_n  <= 1'b0;
         test_mode   <= 1'b0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         frame_addr  <= '0;
         frame_data  <= '0;
         frame_cnt   <= '0;
      end else begin
         frame_valid <= commit_ok;
         frame_err   <= commit_err;
         if (commit_ok) begin
            frame_addr <= addr;
            frame_data <= data;
            frame_cnt  <= frame_cnt + 16'd1;
            unique case (1'b1)
               (addr >= 4'h1 && addr <= 4'h8):
                  rows_q[{addr_m1[2:0], 3'b000} +: 8] <= data;
               (addr == 4'h9): decode_mode <= data;
               (addr == 4'hA): intensity   <= data[3:0];
               (addr == 4'hB): scan_limit  <= data[2:0];
               (addr == 4'hC): shutdown_n  <= data[0];
               (addr == 4'hF): test_mode   <= data[0];
               default: ;
            endcase
         end
      end
   end

`ifdef MAX7219_RX_TEST_OVERRIDE_EN
   assign rows = test_mode ? {64{1'b1}} : rows_q;
`else
   assign rows = rows_q;
`endif

endmodule

// File: tb/tb_max7219_spi_rx_model.sv
// Directed bench for max7219_spi_rx_model.
// Drives SPI frames through the pin interface and checks the register image.
module tb_max7219_spi_rx_model;

   logic        sys_clk;
   logic        _rst;
   logic [63:0] rows;
   logic [7:0]  decode_mode;
   logic [3:0]  intensity;
   logic [2:0]  scan_limit;
   logic        shutdown_n;
   logic        test_mode;
   logic        frame_valid;
   logic [3:0]  frame_addr;
   logic [7:0]  frame_data;
   logic        frame_err;
   logic [15:0] frame_cnt;

   int checks = 0;
   int failures = 0;
   int vcnt = 0;
   int ecnt = 0;
   int v0, e0;
   logic fv3, fv4;

   max7219_spi_rx_model_if spi ();

   max7219_spi_rx_model #(.SYNC_STAGES(2)) dut (
      .sys_clk     (sys_clk),
      ._rst        (_rst),
      .spi         (spi.slave),
      .rows        (rows),
      .decode_mode (decode_mode),
      .intensity   (intensity),
      .scan_limit  (scan_limit),
      .shutdown_n  (shutdown_n),
      .test_mode   (test_mode),
      .frame_valid (frame_valid),
      .frame_addr  (frame_addr),
      .frame_data  (frame_data),
      .frame_err   (frame_err),
      .frame_cnt   (frame_cnt)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) begin
      if (frame_valid) vcnt <= vcnt + 1;
      if (frame_err)   ecnt <= ecnt + 1;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clock_bits(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         spi.Din = v[i];
         spi.CLK = 1'b0;
         cyc(4);
         spi.CLK = 1'b1;
         cyc(4);
      end
      spi.CLK = 1'b0;
      cyc(4);
   endtask

   task automatic send(input logic [31:0] v, input int n);
      spi.CS = 1'b0;
      cyc(4);
      clock_bits(v, n);
      spi.CS = 1'b1;
      cyc(3);
      fv3 = frame_valid;
      cyc(1);
      fv4 = frame_valid;
      cyc(6);
   endtask

   initial begin
      _rst    = 1'b0;
      spi.CS  = 1'b1;
      spi.CLK = 1'b0;
      spi.Din = 1'b0;
      cyc(3);
      chk("rst_rows", rows, 64'h0);
      chk("rst_cnt", frame_cnt, 16'h0);
      chk("rst_valid", frame_valid, 1'b0);
      chk("rst_shdn", shutdown_n, 1'b0);
      _rst = 1'b1;
      cyc(8);
      chk("idle_no_frame", vcnt + ecnt, 0);

      // 1: shutdown register and latency
      v0 = vcnt;
      send(32'h0C01, 16);
      chk("t1_shdn", shutdown_n, 1'b1);
      chk("t1_pulses", vcnt - v0, 1);
      chk("t1_addr", frame_addr, 4'hC);
      chk("t1_data", frame_data, 8'h01);
      chk("t1_cnt", frame_cnt, 16'd1);
      chk("t1_lat_early", fv3, 1'b0);
      chk("t1_lat_hit", fv4, 1'b1);

      // 2: first and last digit
      send(32'h01A5, 16);
      send(32'h083C, 16);
      chk("t2_rows", rows, 64'h3C00_0000_0000_00A5);
      chk("t2_cnt", frame_cnt, 16'd3);

      // 3: short frame
      v0 = vcnt;
      e0 = ecnt;
      send(32'hABC, 12);
      chk("t3_err", ecnt - e0, 1);
      chk("t3_noval", vcnt - v0, 0);
      chk("t3_cnt", frame_cnt, 16'd3);
      chk("t3_rows", rows, 64'h3C00_0000_0000_00A5);
      chk("t3_addr", frame_addr, 4'h8);

      // 4: 20-bit daisy-chain frame keeps last 16 bits
      v0 = vcnt;
      e0 = ecnt;
      send(32'hF0A03, 20);
      chk("t4_int", intensity, 4'h3);
      chk("t4_val", vcnt - v0, 1);
      chk("t4_noerr", ecnt - e0, 0);
      chk("t4_addr", frame_addr, 4'hA);

      // 5: reset mid-frame
      e0 = ecnt;
      spi.CS = 1'b0;
      cyc(4);
      clock_bits(32'h0B, 8);
      _rst = 1'b0;
      cyc(2);
      chk("t5_rst_rows", rows, 64'h0);
      chk("t5_rst_cnt", frame_cnt, 16'h0);
      _rst = 1'b1;
      cyc(3);
      spi.CS = 1'b1;
      cyc(8);
      send(32'h0B05, 16);
      chk("t5_scan", scan_limit, 3'd5);
      chk("t5_cnt", frame_cnt, 16'd1);
      chk("t5_noerr", ecnt - e0, 0);

      // no-op address still counted
      send(32'h0D77, 16);
      chk("noop_cnt", frame_cnt, 16'd2);
      chk("noop_addr", frame_addr, 4'hD);
      chk("noop_rows", rows, 64'h0);

      // 6: test mode
      send(32'h0255, 16);
      chk("t6_digit", rows, 64'h0000_0000_0000_5500);
      send(32'h0F01, 16);
      chk("t6_tm_on", test_mode, 1'b1);
`ifdef MAX7219_RX_TEST_OVERRIDE_EN
      chk("t6_rows_on", rows, {64{1'b1}});
`else
      chk("t6_rows_on", rows, 64'h0000_0000_0000_5500);
`endif
      send(32'h0F00, 16);
      chk("t6_tm_off", test_mode, 1'b0);
      chk("t6_rows_off", rows, 64'h0000_0000_0000_5500);
      chk("t6_cnt", frame_cnt, 16'd5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
